// File: rtl/audio_mix_n.sv
`default_nettype none
// ============================================================================
// audio_mix_n : time-multiplexed N-channel stereo mixer, gain/mute, saturation
// Option AUDIO_MIX_PEAK_EN adds decaying peak meters.        Rev 1.0
// ============================================================================
module audio_mix_n #(
   parameter int                NUM_CH      = 4,
   parameter int                IN_WIDTH    = 16,
   parameter int                OUT_WIDTH   = 16,
   parameter int                GAIN_WIDTH  = 8,
   parameter logic [NUM_CH-1:0] CH_SIGNED   = '0,
   parameter int                DECAY_SHIFT = 4
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 sample_stb_i,
   input  logic [NUM_CH-1:0][IN_WIDTH-1:0]      ch_l_i,
   input  logic [NUM_CH-1:0][IN_WIDTH-1:0]      ch_r_i,
   input  logic [NUM_CH-1:0][GAIN_WIDTH-1:0]    ch_gain_i,
   input  logic [NUM_CH-1:0]                    ch_mute_i,
   output logic [OUT_WIDTH-1:0]                 audio_l_o,
   output logic [OUT_WIDTH-1:0]                 audio_r_o,
   output logic                                 valid_o,
   output logic                                 clip_o,
   output logic                                 overrun_o
`ifdef AUDIO_MIX_PEAK_EN
   ,
   output logic [OUT_WIDTH-2:0]                 peak_l_o,
   output logic [OUT_WIDTH-2:0]                 peak_r_o
`endif
);

   localparam int c_IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int c_ACC_W = IN_WIDTH + GAIN_WIDTH + $clog2(NUM_CH) + 1;
   localparam int c_SAT_W = (c_ACC_W > OUT_WIDTH) ? c_ACC_W : OUT_WIDTH + 1;
   localparam logic [c_IDX_W-1:0]        c_LAST = c_IDX_W'(NUM_CH - 1);
   localparam logic signed [c_SAT_W-1:0] c_MAX  =
      {{(c_SAT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [c_SAT_W-1:0] c_MIN  = ~c_MAX;
   localparam logic [OUT_WIDTH-1:0]      c_OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]      c_OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_SCALE = 2'd2
   } state_t;

   state_t                              state_q, state_d;
   logic [c_IDX_W-1:0]                  idx_q, idx_d;
   // index 0 = left, 1 = right throughout
   logic [NUM_CH-1:0][IN_WIDTH-1:0]     smp_q [2];
   logic [NUM_CH-1:0][IN_WIDTH-1:0]     smp_d [2];
   logic [NUM_CH-1:0][IN_WIDTH-1:0]     cap   [2];
   logic [NUM_CH-1:0][GAIN_WIDTH-1:0]   gain_q, gain_d, cap_gain;
   logic signed [c_ACC_W-1:0]           acc_q [2];
   logic signed [c_ACC_W-1:0]           acc_d [2];
   logic signed [c_ACC_W-1:0]           smp_x [2];
   logic signed [c_ACC_W-1:0]           prod  [2];
   logic signed [c_ACC_W-1:0]           gain_x;
   logic signed [c_SAT_W-1:0]           scaled [2];
   logic [OUT_WIDTH-1:0]                sat   [2];
   logic [OUT_WIDTH-1:0]                audio_q [2];
   logic [OUT_WIDTH-1:0]                audio_d [2];
   logic [1:0]                          clip_side;
   logic                                valid_q, valid_d;
   logic                                clip_q, clip_d;
   logic                                overrun_q, overrun_d;

   // Offset-binary channels get their MSB flipped so everything downstream is signed;
   // a muted channel is captured with zero gain.
   always_comb begin
      for (int n = 0; n < NUM_CH; n++) begin
         cap[0][n] = ch_l_i[n];
         cap[1][n] = ch_r_i[n];
         cap[0][n][IN_WIDTH-1] = ch_l_i[n][IN_WIDTH-1] ~^ CH_SIGNED[n];
         cap[1][n][IN_WIDTH-1] = ch_r_i[n][IN_WIDTH-1] ~^ CH_SIGNED[n];
         cap_gain[n] = ch_mute_i[n] ? '0 : ch_gain_i[n];
      end
   end

   always_comb begin
      gain_x = c_ACC_W'({1'b0, gain_q[idx_q]});
      for (int s = 0; s < 2; s++) begin
         smp_x[s]  = c_ACC_W'($signed(smp_q[s][idx_q]));
         prod[s]   = smp_x[s] * gain_x;
         scaled[s] = c_SAT_W'(acc_q[s] >>> (GAIN_WIDTH - 1));
         if (scaled[s] > c_MAX) begin
            sat[s]       = c_OUT_MAX;
            clip_side[s] = 1'b1;
         end else if (scaled[s] < c_MIN) begin
            sat[s]       = c_OUT_MIN;
            clip_side[s] = 1'b1;
         end else begin
            sat[s]       = scaled[s][OUT_WIDTH-1:0];
            clip_side[s] = 1'b0;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      gain_d    = gain_q;
      valid_d   = 1'b0;
      clip_d    = 1'b0;
      overrun_d = overrun_q;
      for (int s = 0; s < 2; s++) begin
         smp_d[s]   = smp_q[s];
         acc_d[s]   = acc_q[s];
         audio_d[s] = audio_q[s];
      end

      case (state_q)
         S_IDLE: begin
            if (sample_stb_i) begin
               state_d = S_ACCUM;
               idx_d   = '0;
               gain_d  = cap_gain;
               for (int s = 0; s < 2; s++) begin
                  smp_d[s] = cap[s];
                  acc_d[s] = '0;
               end
            end
         end
         S_ACCUM: begin
            for (int s = 0; s < 2; s++) acc_d[s] = acc_q[s] + prod[s];
            idx_d = idx_q + 1'b1;
            if (idx_q == c_LAST) state_d = S_SCALE;
         end
         S_SCALE: begin
            for (int s = 0; s < 2; s++) audio_d[s] = sat[s];
            valid_d = 1'b1;
            clip_d  = |clip_side;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // The SCALE->IDLE cycle still counts as busy.
      if (sample_stb_i && (state_q != S_IDLE)) overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         idx_q     <= '0;
         gain_q    <= '0;
         valid_q   <= 1'b0;
         clip_q    <= 1'b0;
         overrun_q <= 1'b0;
         for (int s = 0; s < 2; s++) begin
            smp_q[s]   <= '0;
            acc_q[s]   <= '0;
            audio_q[s] <= '0;
         end
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         gain_q    <= gain_d;
         valid_q   <= valid_d;
         clip_q    <= clip_d;
         overrun_q <= overrun_d;
         for (int s = 0; s < 2; s++) begin
            smp_q[s]   <= smp_d[s];
            acc_q[s]   <= acc_d[s];
            audio_q[s] <= audio_d[s];
         end
      end
   end

   assign audio_l_o = audio_q[0];
   assign audio_r_o = audio_q[1];
   assign valid_o   = valid_q;
   assign clip_o    = clip_q;
   assign overrun_o = overrun_q;

`ifdef AUDIO_MIX_PEAK_EN
   logic [OUT_WIDTH-2:0] peak_q [2];
   logic [OUT_WIDTH-2:0] peak_d [2];
   logic [OUT_WIDTH-2:0] mag    [2];
   logic [OUT_WIDTH-1:0] neg    [2];

   // The most negative code has no positive twin, so its magnitude clamps to full scale.
   always_comb begin
      for (int s = 0; s < 2; s++) begin
         neg[s]    = -sat[s];
         peak_d[s] = peak_q[s];
         if (sat[s] == c_OUT_MIN)       mag[s] = '1;
         else if (sat[s][OUT_WIDTH-1])  mag[s] = neg[s][OUT_WIDTH-2:0];
         else                           mag[s] = sat[s][OUT_WIDTH-2:0];
         if (state_q == S_SCALE) begin
            if (mag[s] > peak_q[s]) peak_d[s] = mag[s];
            else                    peak_d[s] = peak_q[s] - (peak_q[s] >> DECAY_SHIFT);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int s = 0; s < 2; s++) peak_q[s] <= '0;
      end else begin
         for (int s = 0; s < 2; s++) peak_q[s] <= peak_d[s];
      end
   end

   assign peak_l_o = peak_q[0];
   assign peak_r_o = peak_q[1];
`endif

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_n.sv
`default_nettype none
// tb_audio_mix_n : directed scoreboard bench for audio_mix_n, two instances
// (all-signed and ch0 offset-binary) sharing one stimulus stream.
module tb_audio_mix_n;

   logic               clk = 1'b0;
   logic               reset;
   logic               stb;
   logic [3:0][15:0]   ch_l, ch_r;
   logic [3:0][7:0]    gain;
   logic [3:0]         mute;

   logic [15:0] aud_l, aud_r, ob_l, ob_r;
   logic        valid, clip, ovr, ob_valid, ob_clip, ob_ovr;
`ifdef AUDIO_MIX_PEAK_EN
   logic [14:0] pk_l, pk_r, ob_pk_l, ob_pk_r;
`endif

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] l, r, ol, orr;
      logic        c, oc;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   audio_mix_n #(.NUM_CH(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8),
                 .CH_SIGNED(4'b1111), .DECAY_SHIFT(4)) u_dut (
      .clk(clk), .reset(reset), .sample_stb_i(stb),
      .ch_l_i(ch_l), .ch_r_i(ch_r), .ch_gain_i(gain), .ch_mute_i(mute),
      .audio_l_o(aud_l), .audio_r_o(aud_r), .valid_o(valid), .clip_o(clip),
      .overrun_o(ovr)
`ifdef AUDIO_MIX_PEAK_EN
      , .peak_l_o(pk_l), .peak_r_o(pk_r)
`endif
   );

   audio_mix_n #(.NUM_CH(4), .IN_WIDTH(16), .OUT_WIDTH(16), .GAIN_WIDTH(8),
                 .CH_SIGNED(4'b1110), .DECAY_SHIFT(4)) u_ob (
      .clk(clk), .reset(reset), .sample_stb_i(stb),
      .ch_l_i(ch_l), .ch_r_i(ch_r), .ch_gain_i(gain), .ch_mute_i(mute),
      .audio_l_o(ob_l), .audio_r_o(ob_r), .valid_o(ob_valid), .clip_o(ob_clip),
      .overrun_o(ob_ovr)
`ifdef AUDIO_MIX_PEAK_EN
      , .peak_l_o(ob_pk_l), .peak_r_o(ob_pk_r)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: offset-binary decoded as value-32768, floor divide by 128, clamp.
   function automatic void model(input logic [3:0] mask, input logic [3:0][15:0] sl,
                                 input logic [3:0][7:0] g, input logic [3:0] m,
                                 output logic [15:0] o, output logic c);
      longint acc, s, v;
      acc = 0;
      for (int i = 0; i < 4; i++) begin
         if (!m[i]) begin
            if (mask[i]) s = longint'($signed(sl[i]));
            else         s = longint'(sl[i]) - 32768;
            acc += s * longint'(g[i]);
         end
      end
      v = acc >>> 7;
      c = 1'b0;
      if (v > 32767)       begin o = 16'h7FFF; c = 1'b1; end
      else if (v < -32768) begin o = 16'h8000; c = 1'b1; end
      else                   o = v[15:0];
   endfunction

   task automatic push_expected();
      exp_t e;
      logic cl, cr, ocl, ocr;
      model(4'b1111, ch_l, gain, mute, e.l,  cl);
      model(4'b1111, ch_r, gain, mute, e.r,  cr);
      model(4'b1110, ch_l, gain, mute, e.ol, ocl);
      model(4'b1110, ch_r, gain, mute, e.orr, ocr);
      e.c  = cl | cr;
      e.oc = ocl | ocr;
      sb.push_back(e);
   endtask

   // n0 = edges already elapsed since the strobe was driven.
   task automatic wait_valid(input int n0, input string tag);
      exp_t e;
      int n = n0;
      while (valid !== 1'b1 && n < 30) begin
         tick();
         n++;
      end
      chk({tag, "_latency"}, n, 6);
      chk({tag, "_ob_valid"}, ob_valid, 1'b1);
      chk({tag, "_sb_nonempty"}, (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_l"},     aud_l,   e.l);
         chk({tag, "_r"},     aud_r,   e.r);
         chk({tag, "_clip"},  clip,    e.c);
         chk({tag, "_ob_l"},  ob_l,    e.ol);
         chk({tag, "_ob_r"},  ob_r,    e.orr);
         chk({tag, "_ob_clip"}, ob_clip, e.oc);
      end
   endtask

   task automatic run_pass(input string tag);
      push_expected();
      stb = 1'b1;
      tick();
      stb = 1'b0;
      wait_valid(1, tag);
   endtask

   task automatic count_valids(input int cycles, output int cnt);
      cnt = 0;
      for (int i = 0; i < cycles; i++) begin
         if (valid === 1'b1) cnt++;
         tick();
      end
   endtask

   task automatic set_ch0(input logic [15:0] l, input logic [7:0] g);
      ch_l = '0; ch_r = '0; gain = '0;
      ch_l[0] = l; gain[0] = g; mute = 4'b1110;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nv;
      reset = 1'b1; stb = 1'b0;
      ch_l = '0; ch_r = '0; gain = '0; mute = 4'hF;
      repeat (3) tick();
      chk("rst_l", aud_l, 16'h0);
      chk("rst_r", aud_r, 16'h0);
      chk("rst_valid", valid, 1'b0);
      chk("rst_clip", clip, 1'b0);
      chk("rst_ovr", ovr, 1'b0);
      reset = 1'b0;
      tick();

      // single unity-gain channel
      set_ch0(16'h1000, 8'd128);
      run_pass("t1");
      chk("t1_l_const", aud_l, 16'h1000);
      chk("t1_clip_const", clip, 1'b0);
      tick();
      chk("t1_pulse", valid, 1'b0);

      // two channels, half and near-double gain
      set_ch0(16'h1000, 8'd64);
      ch_l[1] = 16'h0800; gain[1] = 8'd255; mute = 4'b1100;
      run_pass("t2");
      chk("t2_l_const", aud_l, 16'h17F0);

      // saturation both directions
      for (int i = 0; i < 4; i++) begin
         ch_l[i] = 16'h7000; ch_r[i] = 16'h9000; gain[i] = 8'd128;
      end
      mute = 4'b0000;
      run_pass("t3");
      chk("t3_l_const", aud_l, 16'h7FFF);
      chk("t3_r_const", aud_r, 16'h8000);
      chk("t3_clip_const", clip, 1'b1);
      tick();
      chk("t3_clip_pulse", clip, 1'b0);

      // offset-binary ch0 on the second instance
      set_ch0(16'h8000, 8'd128);
      run_pass("t4a");
      chk("t4a_ob_l_const", ob_l, 16'h0000);
      set_ch0(16'hC000, 8'd128);
      run_pass("t4b");
      chk("t4b_ob_l_const", ob_l, 16'h4000);
      chk("t4b_l_const", aud_l, 16'hC000);
      chk("t4_no_ovr", ovr, 1'b0);

      // strobe while busy, inputs changed mid-pass
      set_ch0(16'h1000, 8'd128);
      push_expected();
      stb = 1'b1; tick(); stb = 1'b0; tick();
      ch_l[0] = 16'h2000; gain[0] = 8'd255;
      stb = 1'b1; tick(); stb = 1'b0;
      chk("t5_ovr_set", ovr, 1'b1);
      wait_valid(3, "t5");
      chk("t5_l_const", aud_l, 16'h1000);
      tick();
      count_valids(10, nv);
      chk("t5_single_valid", nv, 0);
      chk("t5_ovr_sticky", ovr, 1'b1);

      // reset in ACCUM at idx=2
      set_ch0(16'h3000, 8'd128);
      stb = 1'b1; tick(); stb = 1'b0;
      tick(); tick();
      reset = 1'b1; tick(); reset = 1'b0;
      chk("t6_l_zero", aud_l, 16'h0);
      chk("t6_r_zero", aud_r, 16'h0);
      chk("t6_ovr_cleared", ovr, 1'b0);
      count_valids(10, nv);
      chk("t6_no_valid", nv, 0);

      set_ch0(16'h4000, 8'd128);
      run_pass("t6b");
      chk("t6b_l_const", aud_l, 16'h4000);
`ifdef AUDIO_MIX_PEAK_EN
      chk("t6b_peak", pk_l, 15'h4000);
`endif
      set_ch0(16'h0000, 8'd128);
      run_pass("t6c");
`ifdef AUDIO_MIX_PEAK_EN
      chk("t6c_peak_decay", pk_l, 15'h3C00);
`endif

      // strobe landing on the SCALE->IDLE edge is ignored
      set_ch0(16'h0123, 8'd128);
      push_expected();
      stb = 1'b1; tick(); stb = 1'b0;
      repeat (4) tick();
      ch_l[0] = 16'h0456;
      stb = 1'b1; tick(); stb = 1'b0;
      wait_valid(6, "t7");
      tick();
      count_valids(10, nv);
      chk("t7_scale_stb_ignored", nv, 0);
      chk("t7_ovr", ovr, 1'b1);

      // back-to-back at full rate: strobe in the valid cycle is accepted
      reset = 1'b1; tick(); reset = 1'b0; tick();
      set_ch0(16'h0200, 8'd128);
      run_pass("t8a");
      ch_l[0] = 16'h0300;
      run_pass("t8b");
      chk("t8_no_ovr", ovr, 1'b0);
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
